// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demux with per-channel output regs and counters.
// Optional DEMUX_ALT_EN: strict A/B alternation driven by a toggle bit.
module demux_1to2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sel_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid_out,
  input  logic             a_ready_in,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid_out,
  input  logic             b_ready_in,
  output logic [15:0]      a_cnt_out,
  output logic [15:0]      b_cnt_out
);

  logic tgt;
  logic acc;
  logic a_load;
  logic b_load;
  logic a_dlv;
  logic b_dlv;

`ifdef DEMUX_ALT_EN
  logic tog;
  logic unused_sel;
  assign unused_sel = sel_in;
  assign tgt = tog;

  // Toggle flips on every accepted word: strict A, B, A, B order
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) tog <= 1'b0;
    else if (acc) tog <= ~tog;
  end
`else
  assign tgt = sel_in;
`endif

  // Target slot is free if empty or draining this cycle
  always_comb begin
    ready_out = 1'b0;
    unique case (1'b1)
      !rst_n_in: ready_out = 1'b0;
      tgt:       ready_out = ~b_valid_out | b_ready_in;
      default:   ready_out = ~a_valid_out | a_ready_in;
    endcase
  end

  assign acc    = valid_in & ready_out;
  assign a_load = acc & ~tgt;
  assign b_load = acc & tgt;
  assign a_dlv  = a_valid_out & a_ready_in;
  assign b_dlv  = b_valid_out & b_ready_in;

  // Channel A register: reload wins over drain, count every delivery
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      a_cnt_out   <= 16'd0;
    end else begin
      if (a_load) begin
        a_out       <= data_in;
        a_valid_out <= 1'b1;
      end else if (a_dlv) begin
        a_valid_out <= 1'b0;
      end
      if (a_dlv) a_cnt_out <= a_cnt_out + 16'd1;
    end
  end

  // Channel B register: same behaviour as A
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      b_out       <= '0;
      b_valid_out <= 1'b0;
      b_cnt_out   <= 16'd0;
    end else begin
      if (b_load) begin
        b_out       <= data_in;
        b_valid_out <= 1'b1;
      end else if (b_dlv) begin
        b_valid_out <= 1'b0;
      end
      if (b_dlv) b_cnt_out <= b_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Scoreboard bench for demux_1to2_stream: per-channel FIFOs of routed words.
// Driver pushes expected words on accept; monitor pops on each delivery.
module tb_demux_1to2_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic        ready;
  logic [7:0]  a;
  logic        av;
  logic        ar = 1'b0;
  logic [7:0]  b;
  logic        bv;
  logic        br = 1'b0;
  logic [15:0] ac;
  logic [15:0] bc;

  int errors = 0;
  int checks = 0;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int unsigned na = 0;
  int unsigned nb = 0;
  bit          tog = 1'b0;

  logic [7:0]  pa;
  logic [7:0]  pb;
  bit          ha = 1'b0;
  bit          hb = 1'b0;

  demux_1to2_stream #(.WIDTH(8)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .data_in     (data),
    .valid_in    (valid),
    .sel_in      (sel),
    .ready_out   (ready),
    .a_out       (a),
    .a_valid_out (av),
    .a_ready_in  (ar),
    .b_out       (b),
    .b_valid_out (bv),
    .b_ready_in  (br),
    .a_cnt_out   (ac),
    .b_cnt_out   (bc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: valid flags, counters, hold stability, delivered data
  always @(negedge clk) begin
    if (!rst_n) begin
      ha = 1'b0;
      hb = 1'b0;
    end else begin
      chk("a_valid", 32'(av), 32'(qa.size() != 0));
      chk("b_valid", 32'(bv), 32'(qb.size() != 0));
      chk("a_cnt", 32'(ac), 32'(na[15:0]));
      chk("b_cnt", 32'(bc), 32'(nb[15:0]));
      if (ha) chk("a_hold", 32'(a), 32'(pa));
      if (hb) chk("b_hold", 32'(b), 32'(pb));
      if (av && ar) begin
        if (qa.size() == 0) chk("a_spurious", 32'(1), 32'(0));
        else chk("a_data", 32'(a), 32'(qa.pop_front()));
        na++;
      end
      if (bv && br) begin
        if (qb.size() == 0) chk("b_spurious", 32'(1), 32'(0));
        else chk("b_data", 32'(b), 32'(qb.pop_front()));
        nb++;
      end
      ha = av && !ar;
      hb = bv && !br;
      pa = a;
      pb = b;
    end
  end

  // One cycle: drive at posedge+1, check ready at negedge, commit at edge
  task automatic step(input logic v, input logic s,
                      input logic [7:0] d,
                      input logic ra, input logic rb);
    logic t;
    logic exp;
    logic acc;
    valid = v;
    sel   = s;
    data  = d;
    ar    = ra;
    br    = rb;
    @(negedge clk);
`ifdef DEMUX_ALT_EN
    t = tog;
`else
    t = s;
`endif
    exp = t ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra);
    chk("ready", 32'(ready), 32'(exp));
    acc = v & exp;
    @(posedge clk);
    if (acc) begin
      if (t) qb.push_back(d);
      else qa.push_back(d);
      tog = ~tog;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    sel   = 1'b0;
    data  = 8'hFF;
    ar    = 1'b0;
    br    = 1'b0;
    #2;
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_a", 32'(a), 32'(0));
    chk("rst_b", 32'(b), 32'(0));
    chk("rst_av", 32'(av), 32'(0));
    chk("rst_bv", 32'(bv), 32'(0));
    chk("rst_ac", 32'(ac), 32'(0));
    chk("rst_bc", 32'(bc), 32'(0));
    qa.delete();
    qb.delete();
    na  = 0;
    nb  = 0;
    tog = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
`ifndef DEMUX_ALT_EN
    chk("first_a", 32'(a), 32'h5A);
    chk("first_bv", 32'(bv), 32'(0));
`endif

    // Backpressure, then drain plus same-edge reload
    do_reset();
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Independence: B flows while A is blocked
    do_reset();
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`ifndef DEMUX_ALT_EN
    chk("indep_a", 32'(a), 32'h33);
    chk("indep_bc", 32'(bc), 32'(1));
`endif

    // Streaming, alternating select
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, i[0], 8'(i + 8'h80), 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("stream_ac", 32'(ac), 32'(4));
    chk("stream_bc", 32'(bc), 32'(4));

    // Randomized traffic with occasional mid-operation reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0));
    end

`ifdef DEMUX_ALT_EN
    // Strict alternation regardless of sel_in
    do_reset();
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("alt_ac", 32'(ac), 32'(2));
    chk("alt_bc", 32'(bc), 32'(2));
    // Blocked B at toggle=B stalls input although A is empty
    do_reset();
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hBB, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hDD, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hDD, 1'b1, 1'b0);
    chk("alt_stall_av", 32'(av), 32'(0));
    chk("alt_stall_b", 32'(b), 32'hBB);
`else
    // Counter wrap on A, B untouched
    do_reset();
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++)
      step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wrap_ac", 32'(ac), 32'(0));
    chk("wrap_bc", 32'(bc), 32'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to2_stream.md
# demux_1to2_stream

Registered 1-to-2 stream demultiplexer: the receive-side counterpart of the 2:1 mux. It takes a single stream of data words with a valid/ready handshake and steers each word to output channel A or channel B. Each channel has a one-entry output register with its own valid/ready handshake and a 16-bit delivered-word counter. It sits after a shared link and fans traffic back out to two consumers.

## Interface
- WIDTH, 8, data word width in bits
- clk_in  input  1  clock; all state updates on the rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  input data word
- valid_in  input  1  data_in is valid this cycle
- sel_in  input  1  routing select: 0 routes to A, 1 routes to B; ignored when DEMUX_ALT_EN is defined
- ready_out  output  1  block accepts data_in this cycle
- a_out  output  WIDTH  channel A data register
- a_valid_out  output  1  channel A holds a word
- a_ready_in  input  1  channel A consumer accepts the word
- b_out  output  WIDTH  channel B data register
- b_valid_out  output  1  channel B holds a word
- b_ready_in  input  1  channel B consumer accepts the word
- a_cnt_out  output  16  count of words delivered on A
- b_cnt_out  output  16  count of words delivered on B

## Operation
- Target channel T: sel_in (0 = A, 1 = B), or the internal toggle bit when DEMUX_ALT_EN is defined.
- ready_out = rst_n_in & (~T_valid_out | T_ready_in). This is combinational from sel_in, a_ready_in and b_ready_in.
- Input accept: valid_in & ready_out. On accept, T_out <= data_in and T_valid_out <= 1.
- Output delivery on channel X: X_valid_out & X_ready_in. On delivery with no same-cycle reload, X_valid_out <= 0 and X_cnt_out <= X_cnt_out + 1.
- Delivery and reload in the same cycle on one channel: the new word is loaded, X_valid_out stays 1, and the counter still increments.
- A and B are independent. A delivery on the non-target channel proceeds regardless of input activity.
- While X_valid_out = 1 and X_ready_in = 0, X_out is held stable. X_valid_out never deasserts without a delivery.
- Counters wrap from 0xFFFF to 0x0000. There is no saturation and no overflow flag.
- When valid_in = 0, ready_out still reflects the target channel's state. No word is accepted.

## Timing
- Latency: a word accepted at edge N appears on X_out with X_valid_out = 1 immediately after edge N, so a consumer can take it at edge N+1.
- Throughput: one word per cycle per channel when the consumer holds ready high. This holds even when every word goes to the same channel.
- Reset, asynchronous:
  - a_out, b_out, a_valid_out, b_valid_out, a_cnt_out, b_cnt_out and the toggle all go to 0.
  - ready_out is forced to 0 while rst_n_in = 0.
- Reset mid-operation: buffered words are discarded and not counted. The first accept after release goes to A (ALT mode) or to sel_in.
- The first rising edge after rst_n_in rises may accept data.
- A change in sel_in while the target is blocked changes the target immediately. No word is committed until the accept edge.

## Configuration
- DEMUX_ALT_EN:
  - Defined: sel_in is ignored. A toggle flip-flop, reset to 0 (A), selects the target and flips on every accepted input word. Routing is strictly A, B, A, B, and a blocked target stalls the input; the block never skips to the other channel.
  - Undefined: routing follows sel_in each cycle and the toggle is not built.

## Test plan
- Reset: rst_n_in = 0 with valid_in = 1 -> all outputs 0, ready_out = 0. After release, data_in = 0x5A, sel_in = 0 -> after one edge, a_out = 0x5A, a_valid_out = 1, b_valid_out = 0.
- Backpressure: a_ready_in = 0, accept 0x11 to A, then offer 0x22 to A -> ready_out = 0 and a_out holds 0x11. Raise a_ready_in -> 0x11 is delivered, a_cnt_out = 1, and 0x22 loads on the same edge.
- Independence: A blocked holding 0x33, sel_in = 1, data 0x44 -> accepted. b_out = 0x44 and is delivered with b_ready_in = 1, giving b_cnt_out = 1, while A still holds 0x33.
- Streaming: both ready = 1, 8 back-to-back words alternating sel_in -> ready_out is high every cycle, each word appears 1 cycle later on the correct channel, a_cnt_out = 4, b_cnt_out = 4.
- Wrap: deliver 65 536 words on A -> a_cnt_out returns to 0x0000 and b_cnt_out is unchanged.
- DEMUX_ALT_EN defined: sel_in tied to 1, words 0x01..0x04 -> 0x01 and 0x03 on A, 0x02 and 0x04 on B. With B blocked and the toggle at B -> ready_out = 0 even though A is empty.
